// File: rtl/instr_mem_arbiter_if.sv
// Miss-port and host-write bus between the instruction caches/host and the
// shared instruction store.
interface instr_mem_arbiter_if #(
    parameter int N_PORTS       = 4,
    parameter int DWIDTH        = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int MEM_ADDR_BITS = 10
);
    logic [N_PORTS-1:0]            req_valid;
    logic [N_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [N_PORTS-1:0]            req_ready;
    logic [DWIDTH-1:0]             rsp_data;
    logic [N_PORTS-1:0]            rsp_valid;
    logic                          wr_en;
    logic [MEM_ADDR_BITS-1:0]      wr_addr;
    logic [DWIDTH-1:0]             wr_data;
    logic                          busy;

    modport master (
        output req_valid, req_addr, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_data, rsp_valid, busy
    );

    modport slave (
        input  req_valid, req_addr, wr_en, wr_addr, wr_data,
        output req_ready, rsp_data, rsp_valid, busy
    );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter over cache miss ports in front of a shared synchronous
// instruction memory; read data returns one cycle after the grant.
module instr_mem_arbiter #(
    parameter int N_PORTS       = 4,
    parameter int DWIDTH        = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    instr_mem_arbiter_if.slave  bus
);
    localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH = 2 ** MEM_ADDR_BITS;
    localparam logic [PW-1:0] LAST_RST = PW'(N_PORTS - 1);

    logic [DWIDTH-1:0]     r_mem [DEPTH];
    logic [DWIDTH-1:0]     r_rd_data;
    logic                  r_oor;
    logic [N_PORTS-1:0]    r_rsp_valid;
    logic [PW-1:0]         r_last_grant;

    logic [ADDR_WIDTH-1:0] w_port_addr [N_PORTS];
    logic [N_PORTS-1:0]    w_req_ready;
    logic [PW-1:0]         w_win;
    logic                  w_found;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_oor;

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_addr
            assign w_port_addr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Search from last_grant+1 with wrap; only req_valid, wr_en and
    // last_grant feed the grant, so there is no address-to-ready path.
    always_comb begin
        int idx;
        idx         = 0;
        w_found     = 1'b0;
        w_win       = r_last_grant;
        w_req_ready = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
        if (bus.wr_en) w_found = 1'b0;
        if (w_found) w_req_ready[w_win] = 1'b1;
    end

    assign w_sel_addr = w_port_addr[w_win];
    assign w_oor      = |(w_sel_addr >> MEM_ADDR_BITS);

    // Memory array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
            r_oor     <= 1'b0;
        end else if (w_found) begin
            r_rd_data <= r_mem[w_sel_addr[MEM_ADDR_BITS-1:0]];
            r_oor     <= w_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= '0;
            r_last_grant <= LAST_RST;
        end else begin
            r_rsp_valid <= w_req_ready;
            if (w_found) r_last_grant <= w_win;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_oor ? '0 : r_rd_data;
    assign bus.busy      = (|bus.req_valid) | (|r_rsp_valid);
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed scenarios for instr_mem_arbiter with hand-computed expectations.
module tb_instr_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MB = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instr_mem_arbiter_if #(.N_PORTS(N), .DWIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_BITS(MB)) bus ();

    instr_mem_arbiter #(.N_PORTS(N), .DWIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_BITS(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int port, input logic [AW-1:0] a);
        bus.req_addr[port*AW +: AW] = a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_valid); end
        checks++;
        if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", bus.rsp_data); end
        checks++;
        if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        $display("reset: rsp_valid=%b rsp_data=%h busy=%b", bus.rsp_valid, bus.rsp_data, bus.busy);
    endtask

    task automatic test_load();
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 16'h1234;
        step();
        bus.wr_en = 1'b0;
        bus.req_valid = 4'b0001;
        set_addr(0, 16'h0005);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL load_ready got %b want 0001", bus.req_ready); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", bus.busy); end
        step();
        bus.req_valid = 4'b0000;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL load_rsp_valid got %b want 0001", bus.rsp_valid); end
        checks++;
        if (bus.rsp_data !== 16'h1234) begin errors++; $display("FAIL load_rsp_data got %h want 1234", bus.rsp_data); end
        $display("load: read mem[5] -> rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);
        step();
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'h1234) begin
            errors++; $display("FAIL load_hold got valid=%b data=%h want 0000/1234", bus.rsp_valid, bus.rsp_data);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rv;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < N; i++) begin
            step();
            bus.wr_en = 1'b1; bus.wr_addr = MB'(16 + i); bus.wr_data = 16'hA000 + DW'(i);
        end
        step();
        bus.wr_en = 1'b0;
        for (int i = 0; i < N; i++) set_addr(i, AW'(16 + i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            step();
            bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                exp_rdy = 4'b0001 << (c % N);
                checks++;
                if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready cyc=%0d got %b want %b", c, bus.req_ready, exp_rdy); end
            end
            if (c > 0) begin
                exp_rv = 4'b0001 << ((c - 1) % N);
                exp_d  = 16'hA000 + DW'((c - 1) % N);
                checks++;
                if (bus.rsp_valid !== exp_rv) begin errors++; $display("FAIL rr_rsp_valid cyc=%0d got %b want %b", c, bus.rsp_valid, exp_rv); end
                checks++;
                if (bus.rsp_data !== exp_d) begin errors++; $display("FAIL rr_rsp_data cyc=%0d got %h want %h", c, bus.rsp_data, exp_d); end
            end
            $display("rr cyc=%0d: req_ready=%b rsp_valid=%b rsp_data=%h", c, bus.req_ready, bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_out_of_range();
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 10'd0; bus.wr_data = 16'h5555;
        step();
        bus.wr_en = 1'b0;
        bus.req_valid = 4'b0100;
        set_addr(2, 16'h0400);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL oor_ready got %b want 0100", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL oor_rsp_valid got %b want 0100", bus.rsp_valid); end
        checks++;
        if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL oor_rsp_data got %h want 0000", bus.rsp_data); end
        $display("oor: addr 0400 -> rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);
        step();
        #1;
        checks++;
        if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL oor_hold got %h want 0000", bus.rsp_data); end
    endtask

    task automatic test_write_priority();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_addr(1, 16'h0020);
        set_addr(3, 16'h0022);
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            bus.wr_en = 1'b1; bus.wr_addr = MB'(32 + c); bus.wr_data = 16'hC000 + DW'(c);
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL wp_ready cyc=%0d got %b want 0000", c, bus.req_ready); end
            $display("wp cyc=%0d: write mem[%0d]=%h req_ready=%b", c, 32 + c, bus.wr_data, bus.req_ready);
            step();
        end
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wp_first_grant got %b want 0010", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 16'hC000) begin
            errors++; $display("FAIL wp_rsp1 got valid=%b data=%h want 0010/c000", bus.rsp_valid, bus.rsp_data);
        end
        bus.req_valid = 4'b1000;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wp_second_grant got %b want 1000", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 16'hC002) begin
            errors++; $display("FAIL wp_rsp2 got valid=%b data=%h want 1000/c002", bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_read_after_write();
        logic [DW-1:0] vals [2];
        vals[0] = 16'h1111;
        vals[1] = 16'hBEEF;
        set_addr(0, 16'h0007);
        for (int r = 0; r < 2; r++) begin
            step();
            bus.wr_en = 1'b1; bus.wr_addr = 10'd7; bus.wr_data = vals[r];
            step();
            bus.wr_en = 1'b0;
            bus.req_valid = 4'b0001;
            step();
            bus.req_valid = 4'b0000;
            #1;
            checks++;
            if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== vals[r]) begin
                errors++; $display("FAIL raw_%0d got valid=%b data=%h want 0001/%h", r, bus.rsp_valid, bus.rsp_data, vals[r]);
            end
            $display("raw %0d: mem[7] -> rsp_data=%h", r, bus.rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        step();
        set_addr(0, 16'h0005);
        set_addr(1, 16'h0007);
        bus.req_valid = 4'b0010;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant got %b want 0010", bus.req_ready); end
        step();
        reset = 1'b0;
        bus.req_valid = 4'b0011;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_valid got %b want 0000", bus.rsp_valid); end
        checks++;
        if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL rm_rsp_data got %h want 0000", bus.rsp_data); end
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant got %b want 0001", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'h1234) begin
            errors++; $display("FAIL rm_rsp got valid=%b data=%h want 0001/1234", bus.rsp_valid, bus.rsp_data);
        end
        $display("reset_mid: post-reset read -> rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);
    endtask

    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_load();
        test_round_robin();
        test_out_of_range();
        test_write_priority();
        test_read_after_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Shared instruction backing store for several directly-mapped caches. Each cache's miss port (address-valid/ready out, data in) connects to one request port. A round-robin arbiter grants one miss per cycle and reads an internal synchronous memory. Read data is returned on the cycle after the grant, which is when a cache in its fill state samples its data input. A write port lets the host load the program before or between runs.

## Interface
- N_PORTS, 4, number of cache miss ports (≥1)
- DWIDTH, 16, instruction word width
- ADDR_WIDTH, 16, request address width (matches the cache address width)
- MEM_ADDR_BITS, 10, internal memory depth is 2**MEM_ADDR_BITS words (≤ ADDR_WIDTH)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req_valid  input  N_PORTS  per-port miss request valid
- req_addr  input  N_PORTS*ADDR_WIDTH  per-port miss address; port i is in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  output  N_PORTS  per-port grant; combinational, one-hot or zero
- rsp_data  output  DWIDTH  read data, shared by all ports
- rsp_valid  output  N_PORTS  one-hot; marks the port whose read data is on rsp_data this cycle
- wr_en  input  1  host write strobe
- wr_addr  input  MEM_ADDR_BITS  host write address
- wr_data  input  DWIDTH  host write data
- busy  output  1  high when any req_valid is high, or when any rsp_valid is high

## Operation
- Arbitration is round-robin over the ports whose req_valid is high.
  - Search order starts at last_grant+1 mod N_PORTS and wraps.
  - The first port found with req_valid high receives req_ready=1.
  - last_grant updates to that port at the clock edge.
  - If no port is granted, last_grant holds.
- Grants follow the request within the same cycle.
  - req_ready[i] depends only on req_valid, wr_en and last_grant, never on req_addr.
  - No combinational path exists from any input of a cache to its own req_ready other than req_valid.
- On a granted request, the memory is read at the address req_addr[MEM_ADDR_BITS-1:0] of the winning port.
- An address is out of range when any bit of req_addr above MEM_ADDR_BITS-1 is 1.
  - The request is still granted.
  - The response is all zeros.
  - The out-of-range condition is registered alongside the read.
- While wr_en=1, host write has priority.
  - All req_ready are 0.
  - mem[wr_addr] <= wr_data at the edge.
  - last_grant holds.
- Memory contents are not affected by reset.
- The response register holds rsp_valid and an out-of-range flag.
- rsp_data is the memory read register, with the out-of-range mask applied.
  - rsp_data holds its last value while no read occurs.
  - rsp_data resets to 0.
- Reset values:
  - last_grant = N_PORTS-1, so port 0 wins first.
  - rsp_valid = 0.
  - rsp_data = 0.
  - busy follows req_valid only.
- Reset in the middle of operation drops any pending response: rsp_valid is 0 in the cycle after reset.

## Timing
- Cycle T: req_valid[i]=1 and the arbiter selects i, so req_ready[i]=1. The request is accepted at the end of T.
- Cycle T+1: rsp_valid[i]=1 and rsp_data = mem[addr]. A cache that moved to its fill state at T samples data here.
- A new grant, to the same or a different port, is allowed in T+1, giving 1 read per cycle sustained.
- Read after write:
  - Write at edge E. A read granted in the cycle after E returns the new data.
  - No grant can coincide with a write, so there is no same-cycle hazard.
- Fairness: with all N ports requesting continuously, each port is granted exactly once every N cycles.
- N_PORTS=1: the arbiter degenerates to req_ready = req_valid & ~wr_en.

## Test plan
- Load: host writes mem[5]=0x1234, then port 0 requests addr 0x0005 → req_ready[0]=1 that cycle; the next cycle gives rsp_valid=4'b0001 and rsp_data=0x1234.
- All 4 ports request continuously from reset → grants are 0,1,2,3,0,1,… on consecutive cycles. Each rsp_valid is a one-hot value one cycle behind its grant.
- Port 2 requests addr 0x0400 with MEM_ADDR_BITS=10 → granted; the next cycle gives rsp_valid[2]=1 and rsp_data=0x0000.
- wr_en held high for 3 cycles while ports 1 and 3 request → req_ready=0 for those 3 cycles. The first grant after the writes goes to port 1 (last_grant unchanged at its reset value of 3).
- Write mem[7]=0xBEEF, then port 0 reads 7 in the next cycle → rsp_data=0xBEEF, not the old value.
- Reset asserted during the cycle in which port 1 is granted → the cycle after reset has rsp_valid=0 and rsp_data=0, and the first post-reset grant goes to port 0.
